led_stripe_encoder: RTL and testbench
=====================================

Name: led_stripe_encoder

Overview:
Parametrised WS2812-class serial LED encoder, successor to the prescaler/selector pair. It generates the high/low pulse timings internally, so external short/long-time counters are no longer needed. Pixel words of PIXEL_BITS (24 GRB or 32 GRBW) arrive through a valid/ready handshake and are shifted MSB-first onto led_stripe_pin. Each frame ends with a latch (reset) low period. It sits between the frame/pixel source and the stripe output pin.

Parameters:
PIXEL_BITS, 24, bits per pixel word (24 or 32)
T0H, 10, clocks high for a '0' bit (25 MHz: 0.4 us)
T1H, 20, clocks high for a '1' bit
T0L, 21, clocks low for a '0' bit
T1L, 11, clocks low for a '1' bit
TRST, 1250, clocks low for the frame latch (>= 50 us)
CNT_W, 11, timing counter width; every timing parameter is between 1 and 2^CNT_W-1
OUT_INV, 0, 1 inverts led_stripe_pin (for an inverting level shifter)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
pixel_data  input  PIXEL_BITS  pixel word, MSB transmitted first
pixel_last  input  1  qualifies pixel_data as last pixel of frame
pixel_valid  input  1  source has a pixel
pixel_ready  output  1  encoder accepts pixel this cycle
busy  output  1  encoder not in IDLE
underrun  output  1  one-cycle pulse: stream starved mid-frame
led_stripe_pin  output  1  registered serial output

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=LATCH, counter=TRST-1, shift register=0, last flag=0.
  - pixel_ready=0, underrun=0, busy=1, pin=OUT_INV (logical low).
- On rstn release, one full TRST latch period runs before the first pixel is accepted.
- States: LATCH, IDLE, HIGH, LOW.
  - LATCH: pin low, counter decrements; at counter==0 go to IDLE.
  - IDLE: pin low, pixel_ready=1, busy=0. When pixel_valid&pixel_ready, load the shift register and last flag, bit index=PIXEL_BITS-1, and go to HIGH with counter=(b?T1H:T0H)-1, where b=pixel_data MSB.
  - HIGH: pin high; at counter==0 go to LOW with counter=(b?T1L:T0L)-1.
  - LOW: pin low; at counter==0:
    - not last bit: shift, decrement index, go to HIGH with the next bit's duration.
    - last bit, and a pixel is accepted this cycle: go directly to HIGH for the new pixel's MSB, with no gap.
    - last bit, last flag=1: go to LATCH, counter=TRST-1.
    - last bit, last flag=0, no pixel: go to IDLE and pulse underrun for 1 cycle.
- pixel_ready=1 only in IDLE, or in LOW when counter==0 on the last bit and last flag=0. It is 0 in LATCH, in HIGH, and on the final LOW of a last-flagged pixel.
- Latency: pixel accepted in cycle n gives pin high from cycle n+1. Each bit's high time is exactly T0H/T1H cycles and its low time exactly T0L/T1L cycles. The pin is registered and glitch-free.
- Pixel duration = sum over bits of (TxH+TxL) cycles; there are no extra cycles between bits or between back-to-back pixels.
- Underrun leaves the pin low. If the gap reaches TRST, the stripe latches; the encoder takes no further action. A new pixel is accepted from IDLE normally.
- pixel_data and pixel_last are sampled only on a handshake; changes at other times are ignored.
- led_stripe_pin = logical level XOR OUT_INV.
- Reset mid-bit aborts immediately: pin low and state per the reset values; the partial pixel is discarded.

Test Plan:
Bench timing for all scenarios: T0H=2, T1H=5, T0L=5, T1L=2, TRST=8, PIXEL_BITS=24.
1. Release reset -> pixel_ready=0 and pin low for 8 cycles, then pixel_ready=1, busy=0.
2. Single pixel 0xA50000 with last=1 -> first 8 bits are 1,0,1,0,0,1,0,1, each '1' high 5 / low 2 and each '0' high 2 / low 5. The remaining 16 bits are '0'. Total 168 cycles, then 8 latch cycles with ready=0, then IDLE.
3. Two pixels back-to-back, 0xFFFFFF (last=0) then 0x000001 (last=1), valid held -> second accepted on the final LOW cycle of the first. The new HIGH starts the next cycle, with no extra low cycle. Total 336 cycles, then latch.
4. One pixel, last=0, valid dropped afterwards -> underrun pulses exactly once after bit 0 low ends and pin stays low. A later pixel is accepted from IDLE.
5. Assert rstn=0 during the HIGH phase of bit 12 -> pin low asynchronously, and the 8-cycle latch restarts after release. No residual bits are sent.
6. PIXEL_BITS=32, OUT_INV=1, pixel 0x80000001 last=1 -> 32 bits at the specified timing with inverted pin polarity. Idle and latch level is 1.

Source files
------------

// File: rtl/led_stripe_encoder.sv
// WS2812-class serial LED encoder: shifts valid/ready pixel words MSB-first onto a
// registered stripe pin with internally generated high/low bit timings and a frame latch.
module led_stripe_encoder #(
    parameter int unsigned PIXEL_BITS = 24,
    parameter int unsigned T0H        = 10,
    parameter int unsigned T1H        = 20,
    parameter int unsigned T0L        = 21,
    parameter int unsigned T1L        = 11,
    parameter int unsigned TRST       = 1250,
    parameter int unsigned CNT_W      = 11,
    parameter bit          OUT_INV    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  pixel_last,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic                  busy,
    output logic                  underrun,
    output logic                  led_stripe_pin,
    output logic [1:0]            state_dbg
);

    // Handshake: a pixel transfers on every clock edge where pixel_valid and
    // pixel_ready are both high; pixel_ready never depends on pixel_valid.

    localparam int unsigned IDX_W = $clog2(PIXEL_BITS);

    localparam logic [CNT_W-1:0] C_T0H  = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] C_T1H  = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] C_T0L  = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] C_T1L  = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] C_TRST = CNT_W'(TRST - 1);

    typedef enum logic [1:0] {LATCH = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [PIXEL_BITS-1:0] shreg, shreg_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic                  last_q, last_n;
    logic                  underrun_q, underrun_n;
    logic                  pin_q;
    logic                  bit_end, last_bit, accept, load;

    assign bit_end  = (cnt == '0);
    assign last_bit = (idx == '0);

    // Ready also opens on the closing LOW cycle of a non-final pixel so frames stream gap-free.
    assign pixel_ready = (state == IDLE) || ((state == LOW) && bit_end && last_bit && !last_q);
    assign accept      = pixel_valid && pixel_ready;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt - CNT_W'(1);
        shreg_n    = shreg;
        idx_n      = idx;
        last_n     = last_q;
        underrun_n = 1'b0;
        load       = 1'b0;
        case (state)
            LATCH: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                cnt_n = cnt;
                load  = accept;
            end
            HIGH: begin
                if (bit_end) begin
                    state_n = LOW;
                    cnt_n   = shreg[PIXEL_BITS-1] ? C_T1L : C_T0L;
                end
            end
            LOW: begin
                if (bit_end) begin
                    if (!last_bit) begin
                        shreg_n = shreg << 1;
                        idx_n   = idx - IDX_W'(1);
                        state_n = HIGH;
                        cnt_n   = shreg[PIXEL_BITS-2] ? C_T1H : C_T0H;
                    end else if (accept) begin
                        load = 1'b1;
                    end else if (last_q) begin
                        state_n = LATCH;
                        cnt_n   = C_TRST;
                    end else begin
                        state_n    = IDLE;
                        cnt_n      = '0;
                        underrun_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = LATCH;
                cnt_n   = C_TRST;
            end
        endcase
        if (load) begin
            shreg_n = pixel_data;
            last_n  = pixel_last;
            idx_n   = IDX_W'(PIXEL_BITS - 1);
            state_n = HIGH;
            cnt_n   = pixel_data[PIXEL_BITS-1] ? C_T1H : C_T0H;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= LATCH;
            cnt        <= C_TRST;
            shreg      <= '0;
            idx        <= '0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            pin_q      <= OUT_INV;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            last_q     <= last_n;
            underrun_q <= underrun_n;
            // Pin follows the next state so it is high exactly while in HIGH, with no decode glitches.
            pin_q      <= (state_n == HIGH) ^ OUT_INV;
        end
    end

    assign busy           = (state != IDLE);
    assign underrun       = underrun_q;
    assign led_stripe_pin = pin_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_led_stripe_encoder.sv
// Directed self-checking bench for led_stripe_encoder: 24-bit normal-polarity and
// 32-bit inverted-polarity instances driven with hand-built pixel vectors.
module tb_led_stripe_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [23:0] data_a = '0;
    logic        last_a = 1'b0;
    logic        valid_a = 1'b0;
    logic        ready_a, busy_a, under_a, pin_a;
    logic [1:0]  st_a;

    logic [31:0] data_b = '0;
    logic        last_b = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_b, busy_b, under_b, pin_b;
    logic [1:0]  st_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_stripe_encoder #(
        .PIXEL_BITS(24), .T0H(2), .T1H(5), .T0L(5), .T1L(2), .TRST(8), .CNT_W(11), .OUT_INV(1'b0)
    ) dut_a (
        .clk(clk), .rstn(rstn), .pixel_data(data_a), .pixel_last(last_a), .pixel_valid(valid_a),
        .pixel_ready(ready_a), .busy(busy_a), .underrun(under_a), .led_stripe_pin(pin_a),
        .state_dbg(st_a)
    );

    led_stripe_encoder #(
        .PIXEL_BITS(32), .T0H(2), .T1H(5), .T0L(5), .T1L(2), .TRST(8), .CNT_W(11), .OUT_INV(1'b1)
    ) dut_b (
        .clk(clk), .rstn(rstn), .pixel_data(data_b), .pixel_last(last_b), .pixel_valid(valid_b),
        .pixel_ready(ready_b), .busy(busy_b), .underrun(under_b), .led_stripe_pin(pin_b),
        .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Per-cycle pin/ready expectations for one pixel; entered on the first HIGH cycle.
    task automatic expect_bits(input bit sel, input logic [31:0] data, input int nbits,
                               input bit last, input bit inv);
        int h, l;
        for (int i = nbits - 1; i >= 0; i--) begin
            h = data[i] ? 5 : 2;
            l = data[i] ? 2 : 5;
            chk("busy_bit", sel ? busy_b : busy_a, 1'b1);
            for (int c = 0; c < h; c++) begin
                chk("pin_high", sel ? pin_b : pin_a, 1'b1 ^ inv);
                chk("ready_high", sel ? ready_b : ready_a, 1'b0);
                @(negedge clk);
            end
            for (int c = 0; c < l; c++) begin
                chk("pin_low", sel ? pin_b : pin_a, inv);
                chk("ready_low", sel ? ready_b : ready_a, (i == 0) && (c == l - 1) && !last);
                chk("underrun_low", sel ? under_b : under_a, 1'b0);
                @(negedge clk);
            end
        end
    endtask

    task automatic expect_latch(input bit sel, input bit inv);
        for (int c = 0; c < 8; c++) begin
            chk("latch_ready", sel ? ready_b : ready_a, 1'b0);
            chk("latch_pin", sel ? pin_b : pin_a, inv);
            chk("latch_busy", sel ? busy_b : busy_a, 1'b1);
            @(negedge clk);
        end
        chk("idle_ready", sel ? ready_b : ready_a, 1'b1);
        chk("idle_busy", sel ? busy_b : busy_a, 1'b0);
        chk("idle_pin", sel ? pin_b : pin_a, inv);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pin_a", pin_a, 1'b0);
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b1);
        chk("rst_under_a", under_a, 1'b0);
        chk("rst_pin_b", pin_b, 1'b1);
        chk("rst_ready_b", ready_b, 1'b0);

        // 1: release reset, 8-cycle latch before ready
        rstn = 1'b1;
        expect_latch(1'b0, 1'b0);
        chk("b_idle_pin", pin_b, 1'b1);
        chk("b_idle_ready", ready_b, 1'b1);

        // 2: single last pixel 0xA50000
        data_a = 24'hA50000; last_a = 1'b1; valid_a = 1'b1;
        chk("t2_ready", ready_a, 1'b1);
        @(negedge clk);
        valid_a = 1'b0; data_a = 24'h5A5A5A; last_a = 1'b0;
        expect_bits(1'b0, 32'h00A50000, 24, 1'b1, 1'b0);
        expect_latch(1'b0, 1'b0);

        // 3: back-to-back 0xFFFFFF then 0x000001, valid held
        data_a = 24'hFFFFFF; last_a = 1'b0; valid_a = 1'b1;
        @(negedge clk);
        data_a = 24'h000001; last_a = 1'b1;
        expect_bits(1'b0, 32'h00FFFFFF, 24, 1'b0, 1'b0);
        valid_a = 1'b0;
        expect_bits(1'b0, 32'h00000001, 24, 1'b1, 1'b0);
        expect_latch(1'b0, 1'b0);

        // 4: non-last pixel then starvation -> one underrun pulse
        data_a = 24'h800000; last_a = 1'b0; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        expect_bits(1'b0, 32'h00800000, 24, 1'b0, 1'b0);
        chk("t4_underrun", under_a, 1'b1);
        chk("t4_pin", pin_a, 1'b0);
        chk("t4_ready", ready_a, 1'b1);
        chk("t4_busy", busy_a, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("t4_underrun_once", under_a, 1'b0);
            chk("t4_pin_idle", pin_a, 1'b0);
        end
        data_a = 24'h000003; last_a = 1'b1; valid_a = 1'b1;
        chk("t4_ready_again", ready_a, 1'b1);
        @(negedge clk);
        valid_a = 1'b0;
        expect_bits(1'b0, 32'h00000003, 24, 1'b1, 1'b0);
        expect_latch(1'b0, 1'b0);

        // 5: reset during HIGH of bit 12 (bits 23..13 of 0x000000 take 77 cycles)
        data_a = 24'h000000; last_a = 1'b1; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        for (int c = 0; c < 77; c++) begin
            chk("t5_pin", pin_a, (c % 7) < 2);
            @(negedge clk);
        end
        chk("t5_bit12_high", pin_a, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_pin", pin_a, 1'b0);
        chk("t5_async_ready", ready_a, 1'b0);
        chk("t5_async_busy", busy_a, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        expect_latch(1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t5_no_residual", pin_a, 1'b0);
            chk("t5_stay_idle", busy_a, 1'b0);
        end

        // 6: 32-bit inverted instance, 0x80000001 last
        chk("t6_idle_pin", pin_b, 1'b1);
        data_b = 32'h80000001; last_b = 1'b1; valid_b = 1'b1;
        chk("t6_ready", ready_b, 1'b1);
        @(negedge clk);
        valid_b = 1'b0;
        expect_bits(1'b1, 32'h80000001, 32, 1'b1, 1'b1);
        expect_latch(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
